axis_uart_tx_arbiter: RTL

AXIS_UART_TX_ARBITER -- requirements
Module: axis_uart_tx_arbiter

---
 rtl/axis_uart_arb_pkg.sv | 13 +
 rtl/rr_priority_select.sv | 34 +++
 rtl/axis_uart_tx_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/axis_uart_arb_pkg.sv
// Shared types for the AXI-Stream UART TX arbiter.
// Holds the FSM state encoding and the default header tag nibble.
package axis_uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA
  } arb_state_e;

  localparam logic [3:0] HEADER_TAG_DEFAULT = 4'hA;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin search: first set request above last_grant, wrapping.
// Ports: req (per-port request), last_grant -> found, next_idx.
module rr_priority_select #(
  parameter int N_PORTS = 4
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [3:0]         last_grant,
  output logic               found,
  output logic [3:0]         next_idx
);

  logic [15:0] req_ext;
  logic [4:0]  cand;

  // Walk offsets from farthest to nearest so the nearest hit wins;
  // offset N_PORTS lands on last_grant itself (lowest priority).
  always_comb begin
    req_ext  = 16'(req);
    found    = 1'b0;
    next_idx = 4'd0;
    cand     = 5'd0;
    for (int k = N_PORTS; k >= 1; k--) begin
      cand = {1'b0, last_grant} + 5'(k);
      if (cand >= 5'(N_PORTS)) begin
        cand = cand - 5'(N_PORTS);
      end
      if (req_ext[cand[3:0]]) begin
        found    = 1'b1;
        next_idx = cand[3:0];
      end
    end
  end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-granular round-robin merge of N byte streams into one UART TX stream.
// Ports: clk, reset, S_AXIS_* (N inputs), M_AXIS_* (merged), GRANT_ID, BUSY.
module axis_uart_tx_arbiter
  import axis_uart_arb_pkg::*;
#(
  parameter int         N_PORTS       = 4,
  parameter int         INSERT_HEADER = 1,
  parameter logic [3:0] HEADER_TAG    = HEADER_TAG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_PORTS*8-1:0] S_AXIS_TDATA,
  input  logic [N_PORTS-1:0]   S_AXIS_TVALID,
  input  logic [N_PORTS-1:0]   S_AXIS_TLAST,
  output logic [N_PORTS-1:0]   S_AXIS_TREADY,
  output logic [7:0]           M_AXIS_TDATA,
  output logic                 M_AXIS_TVALID,
  output logic                 M_AXIS_TLAST,
  input  logic                 M_AXIS_TREADY,
  output logic [3:0]           GRANT_ID,
  output logic                 BUSY
);

  arb_state_e  state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  last_grant_q, last_grant_d;

  logic        found;
  logic [3:0]  next_idx;

  logic [127:0] tdata_ext;
  logic [15:0]  valid_ext;
  logic [15:0]  last_ext;
  logic [7:0]   g_data;
  logic         g_valid;
  logic         g_last;

  rr_priority_select #(
    .N_PORTS (N_PORTS)
  ) u_sel (
    .req        (S_AXIS_TVALID),
    .last_grant (last_grant_q),
    .found      (found),
    .next_idx   (next_idx)
  );

  // Widen to 16 ports so a 4-bit grant indexes without range issues.
  always_comb begin
    tdata_ext = 128'(S_AXIS_TDATA);
    valid_ext = 16'(S_AXIS_TVALID);
    last_ext  = 16'(S_AXIS_TLAST);
    g_data    = tdata_ext[{grant_q, 3'b000} +: 8];
    g_valid   = valid_ext[grant_q];
    g_last    = last_ext[grant_q];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = next_idx;
          state_d = (INSERT_HEADER != 0) ? ST_HEADER : ST_DATA;
        end
      end
      ST_HEADER: begin
        if (M_AXIS_TREADY) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (g_valid && M_AXIS_TREADY && g_last) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, not just after it.
  always_comb begin
    M_AXIS_TDATA  = 8'd0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = '0;
    BUSY          = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_HEADER: begin
          M_AXIS_TVALID = 1'b1;
          M_AXIS_TDATA  = {HEADER_TAG, grant_q};
          BUSY          = 1'b1;
        end
        ST_DATA: begin
          M_AXIS_TDATA  = g_data;
          M_AXIS_TVALID = g_valid;
          M_AXIS_TLAST  = g_last;
          S_AXIS_TREADY = N_PORTS'(M_AXIS_TREADY) << grant_q;
          BUSY          = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign GRANT_ID = grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 4'd0;
      last_grant_q <= 4'(N_PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
